message_blocker: RTL and testbench

Byte-stream to block packer sitting directly upstream of the cipher padding stage. Accepts message bytes over a valid/ready handshake, packs them MSB-first into BWIDTH-bit blocks, and presents each block (full or final partial, zero-filled) with its valid-byte count and a last flag. The padding stage consumes blk_data/blk_bytes/blk_last; this block performs no padding itself.

---
 rtl/message_blocker.sv | 103 ++++++++++
 tb/tb_message_blocker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/message_blocker.sv
// Packs a byte stream MSB-first into BWIDTH-bit blocks for the padding stage.
// Each block carries its valid-byte count and a last flag; short final blocks are zero-filled.
module message_blocker #(
  parameter int BWIDTH = 32,
  localparam int NB = BWIDTH / 8,
  localparam int CW = $clog2(NB) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [BWIDTH-1:0] blk_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [CW-1:0]     blk_bytes,
  output logic              blk_last,
  output logic [15:0]       msg_len
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [BWIDTH-1:0] data_q;
  logic              in_ready_q;
  logic              blk_valid_q;
  logic [CW-1:0]     blk_bytes_q;
  logic              blk_last_q;
  logic [15:0]       msg_len_q;

  logic [BWIDTH-1:0] data_d;
  logic [CW-1:0]     cnt_d;
  logic [15:0]       msg_len_d;
  logic              accept;
  logic              complete;

  assign accept    = in_valid && in_ready_q && (state_q == FILL);
  assign cnt_d     = cnt_q + CW'(1);
  assign complete  = (cnt_d == CW'(NB)) || in_last;
  assign msg_len_d = (msg_len_q == 16'hFFFF) ? msg_len_q : msg_len_q + 16'd1;

  // Lane 0 is the most significant byte; only the lane selected by cnt_q takes the new byte.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign data_d[BWIDTH-1-8*gi -: 8] = (cnt_q == CW'(gi)) ? in_data
                                                            : data_q[BWIDTH-1-8*gi -: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_bytes_q <= '0;
      blk_last_q  <= 1'b0;
      msg_len_q   <= '0;
    end else begin
      case (state_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            msg_len_q <= msg_len_d;
            if (complete) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              blk_valid_q <= 1'b1;
              blk_bytes_q <= cnt_d;
              blk_last_q  <= in_last;
            end
          end
        end
        HOLD: begin
          if (blk_ready) begin
            state_q     <= FILL;
            blk_valid_q <= 1'b0;
            cnt_q       <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            // The message ends with this transfer, so the length restarts for the next one.
            if (blk_last_q) msg_len_q <= '0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign blk_data  = data_q;
  assign blk_valid = blk_valid_q;
  assign blk_bytes = blk_bytes_q;
  assign blk_last  = blk_last_q;
  assign msg_len   = msg_len_q;

endmodule

// File: tb/tb_message_blocker.sv
// Randomized bench for message_blocker: bytes are packed into expected blocks by a
// queue-based model and compared with what the block presents every cycle.
module tb_message_blocker;

  localparam int BW = 32;
  localparam int NB = BW / 8;
  localparam int CW = $clog2(NB) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [BW-1:0] blk_data;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic [CW-1:0] blk_bytes;
  logic          blk_last;
  logic [15:0]   msg_len;

  message_blocker #(.BWIDTH(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_bytes (blk_bytes),
    .blk_last  (blk_last),
    .msg_len   (msg_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    int            bytes;
    bit            last;
  } blk_t;

  blk_t       exp_q[$];
  logic [7:0] part_q[$];
  int         len_m;
  bit         just_reset;
  int         checks = 0;
  int         errors = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check the presented state against the model, then account for transfers.
  task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit br, output bit acc);
    bit   exp_vld;
    bit   exp_rdy;
    blk_t b;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    blk_ready = br;
    exp_vld = (exp_q.size() != 0);
    exp_rdy = !exp_vld && !just_reset;
    check_val("in_ready", in_ready, exp_rdy);
    check_val("blk_valid", blk_valid, exp_vld);
    check_val("msg_len", msg_len, len_m);
    if (exp_vld) begin
      check_val("blk_data", blk_data, exp_q[0].data);
      check_val("blk_bytes", blk_bytes, exp_q[0].bytes);
      check_val("blk_last", blk_last, exp_q[0].last);
    end
    acc = v && exp_rdy;
    if (acc) begin
      part_q.push_back(d);
      if (len_m < 65535) len_m++;
      if (part_q.size() == NB || l) begin
        b.data  = '0;
        b.bytes = part_q.size();
        b.last  = l;
        for (int i = 0; i < part_q.size(); i++) b.data[BW-1-8*i -: 8] = part_q[i];
        exp_q.push_back(b);
        part_q.delete();
      end
    end
    if (exp_vld && br) begin
      b = exp_q.pop_front();
      if (b.last) len_m = 0;
    end
    just_reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Holds a byte on the bus until the block takes it, as a real source would.
  task automatic send(input logic [7:0] d, input bit l, input int br_pct);
    bit acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) cycle(1'b1, d, l, ($urandom_range(0, 99) < br_pct), acc);
    check_val("send_accept", acc, 1'b1);
  endtask

  task automatic drain();
    bit acc;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
    check_val("drain", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_val("rst_in_ready", in_ready, 1'b0);
    check_val("rst_blk_valid", blk_valid, 1'b0);
    check_val("rst_msg_len", msg_len, 16'h0);
    check_val("rst_blk_data", blk_data, '0);
    check_val("rst_blk_bytes", blk_bytes, '0);
    check_val("rst_blk_last", blk_last, 1'b0);
    exp_q.delete();
    part_q.delete();
    len_m = 0;
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    just_reset = 1'b1;
  endtask

  initial begin
    bit   acc;
    int   sent;
    int   n;
    logic [7:0] tog;

    #3;
    apply_reset();

    // Reset in the middle of a block, then a clean full block.
    send(8'hA1, 1'b0, 100);
    send(8'hA2, 1'b0, 100);
    apply_reset();
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b0, 0);
    send(8'h33, 1'b0, 0);
    send(8'h44, 1'b0, 0);
    drain();

    // Eight-byte message spanning two full blocks.
    for (int i = 1; i <= 8; i++) send(8'(i), (i == 8), 100);
    drain();

    // Partial final block and single-byte message.
    send(8'hAA, 1'b0, 100);
    send(8'hBB, 1'b0, 100);
    send(8'hCC, 1'b1, 100);
    drain();
    send(8'h5A, 1'b1, 100);
    drain();

    // Backpressure: junk on the input must be ignored while the block is held.
    for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), 1'b0, 0);
    tog = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, tog, 1'b0, 1'b0, acc);
      tog = ~tog;
    end
    send(8'h55, 1'b0, 100);
    send(8'h66, 1'b1, 100);
    drain();

    // Random messages with input gaps and random backpressure.
    for (int m = 0; m < 150; m++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) cycle(1'b0, 8'h00, 1'b0, ($urandom_range(0, 1) == 1), acc);
        send(8'($urandom), (i == n - 1), 60);
      end
    end
    drain();

    // Length saturation over a very long message.
    sent = 0;
    for (int t = 0; t < 90000 && sent < 65540; t++) begin
      cycle(1'b1, 8'(sent), 1'b0, 1'b1, acc);
      if (acc) sent++;
    end
    check_val("sat_sent", sent, 65540);
    drain();
    check_val("sat_msg_len", msg_len, 16'hFFFF);
    send(8'hE7, 1'b1, 100);
    drain();
    check_val("sat_msg_len_clear", msg_len, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
